// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Brief    : Single-clock FIFO with programmable almost-full/almost-empty
//            thresholds, occupancy count and sticky overflow/underflow flags.
//            Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
//            otherwise reads are registered with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int Data_Width = 8,
    parameter int Depth      = 256,
    parameter int Addr_Width = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [Data_Width-1:0] data_in,
    input  logic                  rd_en,
    output logic [Data_Width-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    input  logic [Addr_Width:0]   af_thresh,
    input  logic [Addr_Width:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_Width:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [Addr_Width:0] c_depth = (Addr_Width + 1)'(Depth);

    logic [Data_Width-1:0] r_mem [Depth];
    logic [Addr_Width:0]   r_wr_ptr;
    logic [Addr_Width:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [Addr_Width:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [Data_Width-1:0] w_head;

    // The extra pointer MSB disambiguates full from empty when the
    // address bits coincide.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == c_depth);
    assign w_empty     = (w_count == '0);
    assign w_wr_accept = wr_en && !w_full;
    assign w_rd_accept = rd_en && !w_empty;
    assign w_head      = r_mem[r_rd_ptr[Addr_Width-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[Addr_Width-1:0]] <= data_in;
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = w_empty ? '0 : w_head;
`else
    logic [Data_Width-1:0] r_data_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_out <= '0;
        end else if (w_rd_accept) begin
            r_data_out <= w_head;
        end
    end

    assign data_out = r_data_out;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= af_thresh);
    assign almost_empty = (w_count <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_prog
// Brief    : Self-checking bench for sync_fifo_prog (Depth 8) using a
//            queue-based reference model; honours SYNC_FIFO_FWFT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf;
    bit            m_unf;

    sync_fifo_prog #(
        .Data_Width (DW),
        .Depth      (DEPTH),
        .Addr_Width (AW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    logic [17:0] act_vec;
    assign act_vec = {full, empty, almost_full, almost_empty, count, overflow, underflow, data_out};

    function automatic logic [17:0] exp_vec();
        int            n;
        logic [DW-1:0] d;
        n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
        d = (n == 0) ? 8'h00 : mq[0];
`else
        d = m_dout;
`endif
        return {n == DEPTH, n == 0, n >= int'(af_thresh), n <= int'(ae_thresh),
                4'(n), m_ovf, m_unf, d};
    endfunction

    // One clock of stimulus; the model applies the acceptance rules using
    // the occupancy seen before the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int n;
        bit aw, ar;
        wr_en = w; data_in = d; rd_en = r; clr_err = c;
        n  = mq.size();
        aw = w && (n != DEPTH);
        ar = r && (n != 0);
        @(posedge clk); #1;
        if (ar) m_dout = mq.pop_front();
        if (aw) mq.push_back(d);
        if (w && n == DEPTH) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && n == 0)     m_unf = 1'b1; else if (c) m_unf = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (act_vec !== exp_vec()) begin
            $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec()); bad++;
        end
        total++;
        if (act_vec !== 18'h1_0000 + 18'h0_4000 + 18'h0_0000) begin
            $display("FAIL reset_literal: got %h expected %h", act_vec, 18'h14000);
            bad++;
        end
        af_thresh = '0;
        #1;
        total++;
        if (almost_full !== 1'b1) begin
            $display("FAIL reset_af_zero: got %b expected 1", almost_full); bad++;
        end
        af_thresh = 4'd6;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals[3];
        vals = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b0, 1'b0);
        total++;
        if (count !== 4'd3 || empty !== 1'b0) begin
            $display("FAIL basic_fill: got count=%0d empty=%b expected count=3 empty=0", count, empty);
            bad++;
        end
        for (int i = 0; i < 3; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            total++;
            if (data_out !== vals[i]) begin
                $display("FAIL basic_read%0d: got %h expected %h", i, data_out, vals[i]); bad++;
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
`else
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (data_out !== vals[i]) begin
                $display("FAIL basic_read%0d: got %h expected %h", i, data_out, vals[i]); bad++;
            end
`endif
        end
        total++;
        if (empty !== 1'b1 || count !== 4'd0 || act_vec !== exp_vec()) begin
            $display("FAIL basic_drain: got %h expected %h", act_vec, exp_vec()); bad++;
        end
    endtask

    task automatic test_thresholds();
        int k;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            k = i + 1;
            total++;
            if (almost_empty !== (k <= 2) || almost_full !== (k >= 6) || full !== (k == 8)
                || count !== 4'(k)) begin
                $display("FAIL thresh_k%0d: got ae=%b af=%b full=%b count=%0d expected ae=%b af=%b full=%b count=%0d",
                         k, almost_empty, almost_full, full, count, k <= 2, k >= 6, k == 8, k);
                bad++;
            end
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            $display("FAIL overflow_set: got ovf=%b count=%0d expected ovf=1 count=8", overflow, count);
            bad++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (overflow !== 1'b0) begin
            $display("FAIL overflow_clr: got %b expected 0", overflow); bad++;
        end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            total++;
            if (data_out !== 8'(8'h40 + i)) begin
                $display("FAIL thresh_data%0d: got %h expected %h", i, data_out, 8'(8'h40 + i)); bad++;
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
`else
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (data_out !== 8'(8'h40 + i)) begin
                $display("FAIL thresh_data%0d: got %h expected %h", i, data_out, 8'(8'h40 + i)); bad++;
            end
`endif
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (underflow !== 1'b1 || count !== 4'd0 || act_vec !== exp_vec()) begin
            $display("FAIL underflow_set: got %h expected %h", act_vec, exp_vec()); bad++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (underflow !== 1'b0) begin
            $display("FAIL underflow_clr: got %b expected 0", underflow); bad++;
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (underflow !== 1'b1) begin
            $display("FAIL underflow_set_wins: got %b expected 1", underflow); bad++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i + 4), 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
            exp_d = 8'(i + 1);
`else
            exp_d = 8'(i);
`endif
            total++;
            if (count !== 4'd4 || data_out !== exp_d || act_vec !== exp_vec()) begin
                $display("FAIL b2b_%0d: got count=%0d data=%h expected count=4 data=%h", i, count, data_out, exp_d);
                bad++;
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        total++;
        if (count !== 4'd7 || overflow !== 1'b1 || full !== 1'b0 || act_vec !== exp_vec()) begin
            $display("FAIL full_simul: got count=%0d ovf=%b full=%b expected count=7 ovf=1 full=0",
                     count, overflow, full);
            bad++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
                $display("FAIL full_drain%0d: got %h expected %h", i, act_vec, exp_vec()); bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hC5, 1'b0, 1'b0);
        total++;
        if (count !== 4'd5 || underflow !== 1'b1) begin
            $display("FAIL mid_pre: got count=%0d unf=%b expected count=5 unf=1", count, underflow); bad++;
        end
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || data_out !== 8'h00 || underflow !== 1'b0
            || overflow !== 1'b0) begin
            $display("FAIL mid_reset: got count=%0d empty=%b data=%h unf=%b ovf=%b expected 0 1 00 0 0",
                     count, empty, data_out, underflow, overflow);
            bad++;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        total++;
        if (data_out !== 8'h5A) begin
            $display("FAIL mid_newdata: got %h expected 5a", data_out); bad++;
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
`else
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (data_out !== 8'h5A) begin
            $display("FAIL mid_newdata: got %h expected 5a", data_out); bad++;
        end
`endif
        total++;
        if (empty !== 1'b1 || act_vec !== exp_vec()) begin
            $display("FAIL mid_after: got %h expected %h", act_vec, exp_vec()); bad++;
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        for (int i = 0; i < 400; i++) begin
            if ((i % 50) == 0) begin
                af_thresh = 4'($urandom_range(0, DEPTH));
                ae_thresh = 4'($urandom_range(0, DEPTH));
            end
            w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            c = ($urandom_range(0, 99) < 5);
            step(w, 8'($urandom), r, c);
            total++;
            if (act_vec !== exp_vec()) begin
                $display("FAIL random_%0d: got %h expected %h", i, act_vec, exp_vec()); bad++;
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_err   = 1'b0;
        data_in   = '0;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        test_reset();
        test_basic();
        test_thresholds();
        test_underflow();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It is the single-clock successor to the team's dual-clock FIFO, for buffering within one clock domain where the consumer needs early back-pressure and occupancy visibility. Read timing is either standard (registered, 1-cycle latency) or first-word-fall-through, selected at compile time.

## Interface
Parameters:
- Data_Width, 8, data word width in bits.
- Depth, 256, number of entries; power of two, ≥ 4.
- Addr_Width, 8, log2(Depth); pointers and count are Addr_Width+1 bits.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- data_in  in  Data_Width  write data, sampled with wr_en.
- rd_en  in  1  read request.
- data_out  out  Data_Width  read data.
- full  out  1  count == Depth.
- empty  out  1  count == 0.
- af_thresh  in  Addr_Width+1  almost-full threshold, quasi-static.
- ae_thresh  in  Addr_Width+1  almost-empty threshold, quasi-static.
- almost_full  out  1  count ≥ af_thresh.
- almost_empty  out  1  count ≤ ae_thresh.
- count  out  Addr_Width+1  current occupancy, 0..Depth.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

## Operation
- Storage: Depth × Data_Width array, addressed by wr_ptr[Addr_Width-1:0] / rd_ptr[Addr_Width-1:0].
- wr_ptr, rd_ptr are Addr_Width+1 bits, wrap modulo 2·Depth; count = wr_ptr − rd_ptr (modulo 2^(Addr_Width+1)).
- Write accepted iff wr_en && !full: store data_in at wr_ptr, wr_ptr+1.
- Read accepted iff rd_en && !empty: rd_ptr+1.
- Acceptance uses flags at the start of the cycle. A write while full is rejected even with a simultaneous accepted read. A read while empty is rejected even with a simultaneous accepted write.
- Simultaneous accepted write and read: count unchanged.
- full, empty, almost_full, almost_empty, count are combinational from the registered pointers and thresholds.
- overflow set on wr_en && full; underflow set on rd_en && empty. Both hold until clr_err. If a set and clr_err occur in the same cycle, set wins.
- Rejected operations never modify pointers, memory, or data_out.
- Reset (rstn low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, overflow = underflow = 0, data_out = 0.
  - almost_full follows count ≥ af_thresh; it is 1 in reset only if af_thresh = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data.

## Timing
- Write-to-empty-deassert: 1 cycle; empty falls after the edge that accepts the first write.
- Standard mode:
  - data_out is registered and loads the head word on the edge accepting a read, visible the following cycle.
  - data_out holds its last value otherwise.
- FWFT mode:
  - data_out shows the head word combinationally whenever !empty.
  - An accepted read advances to the next word after the edge.
  - data_out is 0 while empty.
- Flags and count update on the same edge as the pointer change; there is no extra pipeline delay.
- Throughput: one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_FWFT_EN:
  - Defined: first-word-fall-through read (0-cycle read latency, data_out valid when !empty).
  - Undefined: standard registered read with 1-cycle latency after accepted rd_en.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then write 0x11,0x22,0x33 over 3 cycles -> count=3, empty=0. Then read 3 -> data_out 0x11,0x22,0x33 in order (standard: each one cycle after rd_en; FWFT: 0x11 visible before first rd_en). Final state: empty=1, count=0.
- Depth=8, af_thresh=6, ae_thresh=2, write 8 -> almost_empty drops at count=3, almost_full rises at count=6, full=1 at count=8. A 9th write -> overflow=1, count stays 8, no data corrupted.
- Empty FIFO, rd_en=1 -> underflow=1, pointers unchanged. Pulse clr_err -> underflow=0. clr_err concurrent with a new rd_en on empty -> underflow remains 1.
- Count=4, simultaneous wr_en and rd_en for 20 cycles with incrementing data -> count stays 4, pointers wrap past 2·Depth, output sequence matches input order.
- Full FIFO, simultaneous wr_en and rd_en -> read accepted, write rejected, overflow=1, count=7.
- Count=5, assert rstn low mid-cycle -> immediately count=0, empty=1, data_out=0, flags cleared. After release, the next write/read pair returns the new data only.
